// File: rtl/pad_frame_rx_if.sv
// Core-facing receive interface of pad_frame_rx.
// Handshake: rx_valid high means rx_data holds an unconsumed word; the word is
// taken on any rising CK edge where rx_valid=1 and rx_ready=1. rx_data is
// stable while rx_valid=1. frame_err/overrun/parity_err are one-cycle pulses.
// master = receiver (drives the word), slave = core (drives rx_ready).
interface pad_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/pad_frame_rx.sv
// pad_frame_rx: core-side receiver of the single-wire half-duplex pad link.
// Synchronizes pad_c, deserializes start/data(LSB first)/[parity]/stop frames,
// hands the word to the core and drives a one-cycle ACK(0)/NAK(1) back onto
// the pad between released-line turnaround gaps.
// Optional feature macro: PAD_FRAME_RX_PARITY_EN adds an even-parity bit
// (PAR state) between the data bits and the stop bit.
// dbg_state exposes the FSM state for checkers.
module pad_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 1
) (
  input  logic                CK,
  input  logic                RN,
  input  logic                pad_c,
  output logic                pad_i,
  output logic                pad_oen,
  output logic [2:0]          dbg_state,
  pad_frame_rx_if.master      rx_if
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_PAR   = 3'd2,
    S_STOP  = 3'd3,
    S_TURN1 = 3'd4,
    S_ACK   = 3'd5,
    S_TURN2 = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [TW-1:0]            tcnt_q, tcnt_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic [DATA_W-1:0]        rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     nak_q, nak_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     parity_err_q, parity_err_d;
  logic                     pad_i_q, pad_i_d;
  logic                     pad_oen_q, pad_oen_d;
  logic                     s;
  logic                     par_bad;
`ifdef PAD_FRAME_RX_PARITY_EN
  logic                     par_q, par_d;
`endif

  // Synchronizer shift: pad_c enters at bit 0, s is the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_c};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PAD_FRAME_RX_PARITY_EN
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    nak_d        = nak_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
`ifdef PAD_FRAME_RX_PARITY_EN
    par_d        = par_q;
`endif
    // Consumption; a load in STOP below overrides it on the same edge.
    if (rx_valid_q && rx_if.rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!s) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = s;
        if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef PAD_FRAME_RX_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PAD_FRAME_RX_PARITY_EN
      S_PAR: begin
        par_d   = s;
        state_d = S_STOP;
      end
`endif
      S_STOP: begin
        state_d = S_TURN1;
        tcnt_d  = '0;
        // Priority: framing, then parity, then overrun; only one pulse.
        if (!s) begin
          frame_err_d = 1'b1;
          nak_d       = 1'b1;
        end else if (par_bad) begin
          parity_err_d = 1'b1;
          nak_d        = 1'b1;
        end else if (rx_valid_q && !rx_if.rx_ready) begin
          overrun_d = 1'b1;
          nak_d     = 1'b1;
        end else begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          nak_d      = 1'b0;
        end
      end
      S_TURN1: begin
        if (tcnt_q == TW'(TURN_CYC - 1)) begin
          state_d = S_ACK;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_ACK: begin
        state_d = S_TURN2;
        tcnt_d  = '0;
      end
      S_TURN2: begin
        if (tcnt_q == TW'(TURN_CYC - 1)) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pad controls are decoded from the next state so the flops drive the pad directly.
    pad_oen_d = (state_d != S_ACK);
    pad_i_d   = (state_d == S_ACK) ? nak_q : 1'b1;
  end

  // State and datapath registers; reset releases the pad at once.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      nak_q        <= 1'b1;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      pad_i_q      <= 1'b1;
      pad_oen_q    <= 1'b1;
`ifdef PAD_FRAME_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      nak_q        <= nak_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      pad_i_q      <= pad_i_d;
      pad_oen_q    <= pad_oen_d;
`ifdef PAD_FRAME_RX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign pad_i            = pad_i_q;
  assign pad_oen          = pad_oen_q;
  assign dbg_state        = state_q;
  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;
  assign rx_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_pad_frame_rx.sv
// Testbench for pad_frame_rx (default parameters). Directed frames are driven
// onto pad_c; expected events (load/pulse/ACK slot, each tagged with the edge
// it must appear after) go into exp_q, and a negedge monitor pops and compares
// every event the DUT presents. Build with +define+PAD_FRAME_RX_PARITY_EN to
// add the parity frames.
module tb_pad_frame_rx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TURN = 1;
`ifdef PAD_FRAME_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int E = SYNC + 1 + DW + PB;  // stop-sample edge
  localparam int W = 27;                  // {cycle[15:0], kind[2:0], data[7:0]}

  localparam logic [2:0] K_LOAD = 3'd1;
  localparam logic [2:0] K_ACK  = 3'd2;
  localparam logic [2:0] K_FE   = 3'd3;
  localparam logic [2:0] K_OV   = 3'd4;
  localparam logic [2:0] K_PE   = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_TURN2 = 3'd6;

  // ---------------- clock / reset ----------------
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       pad_c = 1'b1;
  logic       pad_i;
  logic       pad_oen;
  logic [2:0] dbg_state;

  pad_frame_rx_if #(.DATA_W(DW)) rx_if ();

  pad_frame_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC), .TURN_CYC(TURN)) dut (
    .CK        (CK),
    .RN        (RN),
    .pad_c     (pad_c),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .dbg_state (dbg_state),
    .rx_if     (rx_if)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] mk(input int c, input logic [2:0] k, input logic [7:0] d);
    return {16'(c), k, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input logic [2:0] k, input logic [7:0] d);
    logic [W-1:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got cyc=%0d kind=%0d data=%0h, expected none", cyc, k, d);
    end else begin
      e = exp_q.pop_front();
      if (e !== mk(cyc, k, d)) begin
        n_bad++;
        $display("FAIL event: got cyc=%0d kind=%0d data=%0h, expected cyc=%0d kind=%0d data=%0h",
                 cyc, k, d, e[26:11], e[10:8], e[7:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge CK) begin
    if (rx_if.frame_err)  observe(K_FE, 8'h00);
    if (rx_if.parity_err) observe(K_PE, 8'h00);
    if (rx_if.overrun)    observe(K_OV, 8'h00);
    if (rx_if.rx_valid && (!prev_valid || rx_if.rx_data != prev_data))
      observe(K_LOAD, rx_if.rx_data);
    if (!pad_oen) observe(K_ACK, {7'd0, pad_i});
    prev_valid = rx_if.rx_valid;
    prev_data  = rx_if.rx_data;
  end

  // ---------------- driver tasks ----------------
  // Returns 1 time unit after the posedge that brings cyc to c.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CK);
      #1;
    end
  endtask

  // Drives one frame; t0 is the edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            output int t0);
    t0 = cyc + 1;
    pad_c = 1'b0;
    wait_cyc(t0);
    for (int k = 0; k < DW; k++) begin
      pad_c = d[k];
      wait_cyc(t0 + 1 + k);
    end
`ifdef PAD_FRAME_RX_PARITY_EN
    pad_c = (^d) ^ par_flip;
    wait_cyc(t0 + 1 + DW);
`endif
    pad_c = stop_b;
    wait_cyc(t0 + 1 + DW + PB);
    pad_c = 1'b1;
  endtask

  task automatic expect_frame(input int t0, input logic [2:0] k, input logic [7:0] d,
                              input logic ack_bit);
    exp_q.push_back(mk(t0 + E, k, d));
    exp_q.push_back(mk(t0 + E + TURN, K_ACK, {7'd0, ack_bit}));
  endtask

  // Checks the turnaround ends exactly on edge E+2*TURN+1.
  task automatic finish_frame(input int t0, input string tag);
    wait_cyc(t0 + E + 2 * TURN);
    check({tag, "_turn2"}, 32'(dbg_state), 32'(ST_TURN2));
    wait_cyc(t0 + E + 2 * TURN + 1);
    check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         t0;
    logic [7:0] d;
    rx_if.rx_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge CK);
    #1;
    check("rst_oen",   32'(pad_oen), 32'd1);
    check("rst_pad_i", 32'(pad_i), 32'd1);
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_data",  32'(rx_if.rx_data), 32'd0);
    RN = 1'b1;
    wait_cyc(cyc + 20);
    check("idle_oen",   32'(pad_oen), 32'd1);
    check("idle_pad_i", 32'(pad_i), 32'd1);
    check("idle_valid", 32'(rx_if.rx_valid), 32'd0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // 0xA5 into an empty holding register: load, ACK
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    expect_frame(t0, K_LOAD, 8'hA5, 1'b0);
    finish_frame(t0, "a5");
    check("a5_data", 32'(rx_if.rx_data), 32'hA5);

    // 0x3C while 0xA5 held, not consumed: overrun, NAK, data kept
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    expect_frame(t0, K_OV, 8'h00, 1'b1);
    finish_frame(t0, "ovr");
    check("ovr_data",  32'(rx_if.rx_data), 32'hA5);
    check("ovr_valid", 32'(rx_if.rx_valid), 32'd1);

    // 0x3C with consume exactly on the stop edge: load, no overrun
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    expect_frame(t0, K_LOAD, 8'h3C, 1'b0);
    wait_cyc(t0 + E - 1);
    rx_if.rx_ready = 1'b1;
    wait_cyc(t0 + E);
    rx_if.rx_ready = 1'b0;
    finish_frame(t0, "swap");
    check("swap_data", 32'(rx_if.rx_data), 32'h3C);

    // 0xFF with stop=0 while full: frame_err wins over overrun, NAK
    send_frame(8'hFF, 1'b0, 1'b0, t0);
    expect_frame(t0, K_FE, 8'h00, 1'b1);
    finish_frame(t0, "ferr");
    check("ferr_valid", 32'(rx_if.rx_valid), 32'd1);
    check("ferr_data",  32'(rx_if.rx_data), 32'h3C);

    // Consume the held word
    rx_if.rx_ready = 1'b1;
    wait_cyc(cyc + 1);
    rx_if.rx_ready = 1'b0;
    check("consume_valid", 32'(rx_if.rx_valid), 32'd0);

    // 0x5A loaded, then reset during its ACK slot
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    exp_q.push_back(mk(t0 + E, K_LOAD, 8'h5A));
    wait_cyc(t0 + E + TURN);
    check("mid_ack_oen",   32'(pad_oen), 32'd0);
    check("mid_ack_pad_i", 32'(pad_i), 32'd0);
    #1 RN = 1'b0;
    #1;
    check("ack_rst_oen",   32'(pad_oen), 32'd1);
    check("ack_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("ack_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    wait_cyc(cyc + 2);
    RN = 1'b1;
    wait_cyc(cyc + 3);

    // Reset during data bit 4 of 0x55
    d = 8'h55;
    t0 = cyc + 1;
    pad_c = 1'b0;
    wait_cyc(t0);
    for (int k = 0; k < 5; k++) begin
      pad_c = d[k];
      wait_cyc(t0 + 1 + k);
    end
    check("mid_data_state", 32'(dbg_state), 32'(ST_DATA));
    RN = 1'b0;
    #1;
    check("data_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("data_rst_oen",   32'(pad_oen), 32'd1);
    check("data_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    pad_c = 1'b1;
    wait_cyc(cyc + 2);
    RN = 1'b1;
    wait_cyc(cyc + 4);

    // Clean 0x01 after release
    send_frame(8'h01, 1'b1, 1'b0, t0);
    expect_frame(t0, K_LOAD, 8'h01, 1'b0);
    finish_frame(t0, "x01");
    check("x01_data", 32'(rx_if.rx_data), 32'h01);
    rx_if.rx_ready = 1'b1;
    wait_cyc(cyc + 1);
    rx_if.rx_ready = 1'b0;

`ifdef PAD_FRAME_RX_PARITY_EN
    // 0x07 with correct even parity (1): load, ACK
    send_frame(8'h07, 1'b1, 1'b0, t0);
    expect_frame(t0, K_LOAD, 8'h07, 1'b0);
    finish_frame(t0, "par_ok");
    rx_if.rx_ready = 1'b1;
    wait_cyc(cyc + 1);
    rx_if.rx_ready = 1'b0;
    // 0x07 with parity bit 0: parity_err, NAK, no load
    send_frame(8'h07, 1'b1, 1'b1, t0);
    expect_frame(t0, K_PE, 8'h00, 1'b1);
    finish_frame(t0, "par_bad");
    check("par_bad_valid", 32'(rx_if.rx_valid), 32'd0);
`endif

    wait_cyc(cyc + 5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
